// File: rtl/linedraw_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
// Holds the FSM state encoding, the default coordinate width and the
// signed error-term width used by the top and the step datapath.
package linedraw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

    localparam int COORD_W_DEF = 10;

    // Error terms need two extra bits: one for the sign and one because
    // dx + dy and the accumulated err can swing to about twice a coordinate.
    localparam int ERR_W = COORD_W_DEF + 2;

    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/linedraw_step.sv
// One Bresenham step: given the current point and error term, produce the
// next point and error term. Purely combinational; sequencing lives in the top.
// sx/sy encode the step direction: 1 means +1, 0 means -1.
module linedraw_step
    import linedraw_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int EW      = err_width(COORD_W)
) (
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  logic                sx,
    input  logic                sy,
    output logic [COORD_W-1:0]  x_next,
    output logic [COORD_W-1:0]  y_next,
    output logic signed [EW-1:0] err_next
);

    logic signed [EW:0] e2;
    logic signed [EW:0] dx_ext;
    logic signed [EW:0] dy_ext;

    // Decide the x and y moves from e2 = 2*err; both may fire in one step.
    always_comb begin
        e2       = {err, 1'b0};
        dx_ext   = {dx[EW-1], dx};
        dy_ext   = {dy[EW-1], dy};
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (e2 >= dy_ext) begin
            err_next = err_next + dy;
            x_next   = sx ? x + COORD_W'(1) : x - COORD_W'(1);
        end
        if (e2 <= dx_ext) begin
            err_next = err_next + dx;
            y_next   = sy ? y + COORD_W'(1) : y - COORD_W'(1);
        end
    end

endmodule

// File: rtl/bresenham_linedrawer.sv
// Line rasteriser for the oscilloscope trace path. Walks every pixel of a
// segment (x0,y0)-(x1,y1) with integer Bresenham in all octants and hands
// each pixel to the framebuffer writer over a plot_px/plot_ready handshake.
// Optional build macro LINEDRAW_CLIP_EN: points outside H_RES x V_RES are
// stepped over without being presented.
module bresenham_linedrawer
    import linedraw_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               plot_px,
    input  logic               plot_ready,
    output logic               done
);

    localparam int EW = err_width(COORD_W);

    state_t state;

    // Latched endpoints; h/v double as the current Bresenham point.
    logic [COORD_W-1:0]  xs;
    logic [COORD_W-1:0]  ys;
    logic [COORD_W-1:0]  xe;
    logic [COORD_W-1:0]  ye;
    logic signed [EW-1:0] err;
    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic                sx;
    logic                sy;

    logic [COORD_W-1:0]  abs_x;
    logic [COORD_W-1:0]  abs_y;
    logic signed [EW-1:0] init_dx;
    logic signed [EW-1:0] init_dy;

    logic [COORD_W-1:0]  nx;
    logic [COORD_W-1:0]  ny;
    logic signed [EW-1:0] nerr;

    logic at_end;
    logic advance;
    logic init_vis;
    logic next_vis;

    // Segment set-up terms derived from the latched endpoints.
    always_comb begin
        abs_x   = (xe >= xs) ? xe - xs : xs - xe;
        abs_y   = (ye >= ys) ? ye - ys : ys - ye;
        init_dx = {2'b00, abs_x};
        init_dy = EW'(0) - {2'b00, abs_y};
    end

    assign at_end = (h == xe) && (v == ye);

`ifdef LINEDRAW_CLIP_EN
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    // In DRAW a low plot_px means the current point is clipped, so step on
    // without waiting for the writer.
    assign init_vis = ({1'b0, xs} < H_LIM) && ({1'b0, ys} < V_LIM);
    assign next_vis = ({1'b0, nx} < H_LIM) && ({1'b0, ny} < V_LIM);
    assign advance  = plot_ready || !plot_px;
`else
    assign init_vis = 1'b1;
    assign next_vis = 1'b1;
    assign advance  = plot_ready;
`endif

    linedraw_step #(
        .COORD_W (COORD_W),
        .EW      (EW)
    ) u_step (
        .x        (h),
        .y        (v),
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .sx       (sx),
        .sy       (sy),
        .x_next   (nx),
        .y_next   (ny),
        .err_next (nerr)
    );

    // Control FSM with registered outputs: latch, set up, walk, signal done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            h       <= '0;
            v       <= '0;
            plot_px <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            xs      <= '0;
            ys      <= '0;
            xe      <= '0;
            ye      <= '0;
            err     <= '0;
            dx      <= '0;
            dy      <= '0;
            sx      <= 1'b0;
            sy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    plot_px <= 1'b0;
                    if (start) begin
                        xs    <= x0;
                        ys    <= y0;
                        xe    <= x1;
                        ye    <= y1;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    dx      <= init_dx;
                    dy      <= init_dy;
                    err     <= init_dx + init_dy;
                    sx      <= (xs < xe);
                    sy      <= (ys < ye);
                    h       <= xs;
                    v       <= ys;
                    plot_px <= init_vis;
                    state   <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            plot_px <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            h       <= nx;
                            v       <= ny;
                            err     <= nerr;
                            plot_px <= next_vis;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
